// File: rtl/mul_div_unit_pkg.sv
// Shared types and constants for the iterative signed multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mul_div_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam int ITER = 32;
  localparam int WORD = 32;

  // Magnitude of a two's-complement word; -2^31 maps to 32'h80000000 read as unsigned.
  function automatic logic [WORD-1:0] mag(input logic [WORD-1:0] v);
    return v[WORD-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mul_div_unit_booth_step.sv
// One radix-2 Booth iteration: add/sub/none on the upper word, then 65-bit arithmetic right shift.
// Latency: purely combinational.
// Backpressure: none; caller decides when to register the result.
module booth_step
  import mul_div_unit_pkg::*;
(
  input  logic [WORD-1:0] hi,
  input  logic [WORD-1:0] lo,
  input  logic            qm1,
  input  logic [WORD-1:0] m,
  output logic [WORD-1:0] hi_nx,
  output logic [WORD-1:0] lo_nx,
  output logic            qm1_nx
);

  // 33-bit sum keeps the true sign when adding/subtracting a full-range multiplicand.
  logic [WORD:0] sum;

  // Booth recode {lo[0], q-1}, apply the partial product, then shift the whole accumulator right.
  always_comb begin
    sum = {hi[WORD-1], hi};
    case ({lo[0], qm1})
      2'b01:   sum = sum + {m[WORD-1], m};
      2'b10:   sum = sum - {m[WORD-1], m};
      default: sum = {hi[WORD-1], hi};
    endcase
    hi_nx  = sum[WORD:1];
    lo_nx  = {sum[0], lo[WORD-1:1]};
    qm1_nx = lo[0];
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32x32 signed multiplier (Booth radix-2) and signed restoring divider.
// Latency: fixed 33 cycles from the start-sampling edge to the done pulse, for both ops.
// Backpressure: start is ignored while busy; results are held until the next completion.
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  input  logic            op,
  input  logic [WORD-1:0] a,
  input  logic [WORD-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [WORD-1:0] hi,
  output logic [WORD-1:0] lo,
  output logic            dbz
);

  state_t          state, state_nx;
  logic [4:0]      cnt;
  logic            op_r;
  logic            sa, sb;
  logic [WORD-1:0] a_r;
  // Multiply: raw multiplier. Divide: divisor magnitude (signs kept in sa/sb).
  logic [WORD-1:0] b_r;
  // Accumulator {acc_hi, acc_lo, acc_q}; divide reuses acc_hi as remainder, acc_lo as quotient.
  logic [WORD-1:0] acc_hi, acc_lo;
  logic            acc_q;

  logic [WORD-1:0] bth_hi, bth_lo;
  logic            bth_q;
  logic [WORD:0]   div_sh, div_diff;
  logic [WORD-1:0] fin_hi, fin_lo;
  logic            fin_dbz;

  booth_step u_booth (
    .hi     (acc_hi),
    .lo     (acc_lo),
    .qm1    (acc_q),
    .m      (a_r),
    .hi_nx  (bth_hi),
    .lo_nx  (bth_lo),
    .qm1_nx (bth_q)
  );

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state: IDLE waits for start, RUN spans ITER iterations, FIN is a single cycle.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? RUN : IDLE;
      RUN:     state_nx = (cnt == 5'(ITER - 1)) ? FIN : RUN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy = (state == RUN) || (state == FIN);
  end

  // Restoring divide step: shift in the next dividend bit and try to subtract the divisor.
  always_comb begin
    div_sh   = {acc_hi, acc_lo[WORD-1]};
    div_diff = div_sh - {1'b0, b_r};
  end

  // Final result: multiply is taken as-is; divide gets sign fix-up or the divide-by-zero pattern.
  always_comb begin
    fin_hi  = acc_hi;
    fin_lo  = acc_lo;
    fin_dbz = 1'b0;
    if (op_r == OP_DIV) begin
      if (b_r == '0) begin
        fin_dbz = 1'b1;
        fin_lo  = '1;
        fin_hi  = a_r;
      end else begin
        fin_lo = (sa ^ sb) ? (~acc_lo + 1'b1) : acc_lo;
        fin_hi = sa ? (~acc_hi + 1'b1) : acc_hi;
      end
    end
  end

  // Datapath: latch operands on accept, iterate in RUN, publish results and pulse done in FIN.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt    <= '0;
      op_r   <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      acc_q  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      dbz    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start) begin
            op_r   <= op;
            sa     <= a[WORD-1];
            sb     <= b[WORD-1];
            a_r    <= a;
            b_r    <= (op == OP_DIV) ? mag(b) : b;
            acc_hi <= '0;
            acc_lo <= (op == OP_DIV) ? mag(a) : b;
            acc_q  <= 1'b0;
          end
        end
        RUN: begin
          cnt <= cnt + 5'd1;
          if (op_r == OP_MUL) begin
            acc_hi <= bth_hi;
            acc_lo <= bth_lo;
            acc_q  <= bth_q;
          end else if (!div_diff[WORD]) begin
            acc_hi <= div_diff[WORD-1:0];
            acc_lo <= {acc_lo[WORD-2:0], 1'b1};
          end else begin
            acc_hi <= div_sh[WORD-1:0];
            acc_lo <= {acc_lo[WORD-2:0], 1'b0};
          end
        end
        FIN: begin
          cnt  <= '0;
          hi   <= fin_hi;
          lo   <= fin_lo;
          dbz  <= fin_dbz;
          done <= 1'b1;
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases, randomized ops, abort by clr.
// Latency: expects done exactly 33 cycles after the start-sampling edge.
// Backpressure: exercises start pulses while busy and start held during clr.
module tb_mul_div_unit;

  logic        clk;
  logic        clr;
  logic        start;
  logic        op;
  logic [31:0] a, b;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  int n_chk  = 0;
  int n_fail = 0;

  mul_div_unit dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo),
    .dbz   (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain signed arithmetic in 64-bit integers.
  function automatic void ref_model(input logic o, input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] rhi, output logic [31:0] rlo,
                                    output logic rdbz);
    longint sx, sy, p, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    rdbz = 1'b0;
    if (o == 1'b0) begin
      p   = sx * sy;
      rhi = p[63:32];
      rlo = p[31:0];
    end else if (sy == 0) begin
      rdbz = 1'b1;
      rhi  = x;
      rlo  = 32'hFFFF_FFFF;
    end else begin
      q   = sx / sy;
      r   = sx % sy;
      rhi = r[31:0];
      rlo = q[31:0];
    end
  endfunction

  // Issue one op, disturb inputs while busy, and check latency, hold behaviour and results.
  task automatic run_op(input string tag, input logic o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
    logic [31:0] phi, plo;
    int cyc;
    bit seen;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op = ~o;
    phi = hi; plo = lo;
    check({tag, "_busy"}, 64'(busy), 64'(1));
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 5) begin start = 1'b1; a = 32'd1; b = 32'd1; end
      if (cyc == 6) start = 1'b0;
      if (cyc == 16) check({tag, "_hold"}, {hi, lo}, {phi, plo});
      if (done) seen = 1;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(33));
    check({tag, "_hi"}, 64'(hi), 64'(ehi));
    check({tag, "_lo"}, 64'(lo), 64'(elo));
    check({tag, "_dbz"}, 64'(dbz), 64'(edbz));
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, {63'(0), done}, 64'(0));
  endtask

  initial begin
    logic [31:0] rx, ry, rhi, rlo;
    logic        ro, rdbz;
    int          dn;

    clr = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_hilo", {hi, lo}, 64'(0));
    check("rst_dbz", 64'(dbz), 64'(0));
    @(negedge clk);
    clr = 1'b0;

    run_op("mul_6x7",      1'b0, 32'd6,          32'd7,          32'h0,          32'd42,         1'b0);
    run_op("mul_m3x5",     1'b0, -32'sd3,        32'd5,          32'hFFFF_FFFF,  32'hFFFF_FFF1,  1'b0);
    run_op("mul_maxpos",   1'b0, 32'h7FFF_FFFF,  32'h7FFF_FFFF,  32'h3FFF_FFFF,  32'h0000_0001,  1'b0);
    run_op("mul_maxneg",   1'b0, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  32'h0,          1'b0);
    run_op("div_17_5",     1'b1, 32'd17,         32'd5,          32'd2,          32'd3,          1'b0);
    run_op("div_m17_5",    1'b1, -32'sd17,       32'd5,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0);
    run_op("div_wrap",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          32'h8000_0000,  1'b0);
    run_op("div_9_0",      1'b1, 32'd9,          32'd0,          32'd9,          32'hFFFF_FFFF,  1'b1);

    for (int i = 0; i < 30; i++) begin
      ro = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       begin rx = $urandom; ry = 32'd0; end
        1:       begin rx = 32'h8000_0000; ry = $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h8000_0000; end
        2:       begin rx = 32'($signed($urandom_range(0, 200)) - 100);
                       ry = 32'($signed($urandom_range(1, 20)) - 10); end
        default: begin rx = $urandom; ry = $urandom >> $urandom_range(0, 31); end
      endcase
      ref_model(ro, rx, ry, rhi, rlo, rdbz);
      run_op($sformatf("rnd%0d", i), ro, rx, ry, rhi, rlo, rdbz);
    end

    // Abort: start 6*7, stray start mid-run, then clr mid-RUN.
    @(negedge clk);
    op = 1'b0; a = 32'd6; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (c == 5) begin start = 1'b1; a = 32'd1; b = 32'd1; end
      if (c == 6) start = 1'b0;
    end
    #2;
    clr = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_hilo", {hi, lo}, 64'(0));
    check("abort_done", 64'(done), 64'(0));
    // start held across an edge while clr is still asserted must be dropped.
    @(negedge clk);
    start = 1'b1; a = 32'd3; b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0; start = 1'b0;
    dn = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done) dn++;
      if (c == 0) check("clr_start_busy", 64'(busy), 64'(0));
    end
    check("abort_no_done", 64'(dn), 64'(0));
    run_op("abort_rerun", 1'b0, 32'd6, 32'd7, 32'h0, 32'd42, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and clr.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock shared with the datapath registers.
REQ-003 The block SHALL have port clr, input, 1 bit: asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation, sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 1 bit: 0 = signed multiply, 1 = signed divide; sampled with start.
REQ-006 The block SHALL have port a, input, 32 bits: multiplicand or dividend (Y-register side); sampled with start.
REQ-007 The block SHALL have port b, input, 32 bits: multiplier or divisor (bus side); sampled with start.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking hi/lo valid.
REQ-010 The block SHALL have port hi, output, 32 bits: product upper word or remainder; feeds the Zhigh/HI register d input.
REQ-011 The block SHALL have port lo, output, 32 bits: product lower word or quotient; feeds the Zlow/LO register d input.
REQ-012 The block SHALL have port dbz, output, 1 bit: divide-by-zero flag for the last operation.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and FIN; from IDLE it SHALL go to RUN on start=1 and stay in IDLE otherwise.
REQ-014 RUN SHALL execute exactly 32 iterations, one per clock, tracked by a 5-bit counter running 0..31; at count 31 it SHALL go to FIN.
REQ-015 FIN SHALL last one cycle, load hi/lo/dbz, assert done, then return to IDLE.
REQ-016 Timing: with edge E0 sampling start, iterations SHALL occur on E1..E32, and hi/lo/done SHALL update on E33; done SHALL be high from E33 to E34; fixed latency SHALL be 33 cycles for both ops.
REQ-017 busy SHALL be high in RUN and FIN, and low in IDLE.
REQ-018 start SHALL be ignored while busy=1, with no effect on the operation in progress.
REQ-019 Multiply SHALL use radix-2 Booth recoding on b with a 65-bit accumulator {hi, lo, q-1}; the result SHALL be the exact signed 64-bit product.
REQ-020 Divide SHALL be signed restoring division on magnitudes with sign fix-up in FIN: the quotient SHALL truncate toward zero and the remainder SHALL take the sign of a.
REQ-021 Divide of -2^31 by -1 SHALL give lo=32'h80000000 and hi=0 (wrap), with dbz=0.
REQ-022 For b=0 with op=1: dbz=1, lo=32'hFFFFFFFF, hi=a, and the latency SHALL still be 33 cycles.
REQ-023 hi, lo and dbz SHALL hold their values from FIN until the next FIN or clr; they SHALL NOT change during RUN.
REQ-024 Operands SHALL be latched internally at E0; changes on a, b or op after E0 SHALL NOT affect the result.

Reset
REQ-025 clr=1 SHALL immediately force IDLE, counter=0, busy=0, done=0, hi=0, lo=0, dbz=0 and clear the internal operand/accumulator registers.
REQ-026 clr asserted mid-RUN SHALL abort the operation: no done pulse SHALL follow, and the first start after clr releases SHALL be accepted.
REQ-027 start coincident with clr SHALL be ignored.

Structure
REQ-028 A shared package SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, FIN=2'd2), the op encodings (OP_MUL=1'b0, OP_DIV=1'b1), ITER=32 and WORD=32.
REQ-029 One sub-module, booth_step, SHALL be used: combinational add/sub/none selection from {lo[0], q-1} plus the arithmetic right shift; division SHALL stay inline.

Verification
REQ-030 The bench SHALL cover: op=0, a=6, b=7 -> after 33 cycles done=1, hi=0, lo=42, dbz=0.
REQ-031 The bench SHALL cover: op=0, a=-3, b=5 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFF1.
REQ-032 The bench SHALL cover: op=0, a=b=32'h7FFFFFFF -> hi=32'h3FFFFFFF, lo=32'h00000001; and a=b=32'h80000000 -> hi=32'h40000000, lo=0.
REQ-033 The bench SHALL cover: op=1, a=17, b=5 -> lo=3, hi=2; and a=-17, b=5 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFE.
REQ-034 The bench SHALL cover: op=1, a=9, b=0 -> dbz=1, lo=32'hFFFFFFFF, hi=9, done at cycle 33.
REQ-035 The bench SHALL cover: start 6*7, pulse start again at cycle 5 with a=1, b=1, then assert clr at cycle 10 -> busy=0, hi=lo=0 immediately and no done pulse; a fresh 6*7 afterwards -> lo=42.
